// File: rtl/skew_dispatcher_if.sv
// Load/stream bus between the matrix load path, the skew dispatcher and the systolic array.
// N lanes of W-bit elements; element/lane j sits at bits [j*W +: W] of every packed row.
interface skew_dispatcher_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int RW = $clog2(N);

  logic            load_en;
  logic [RW-1:0]   load_row;
  logic [N*W-1:0]  load_r;
  logic [N*W-1:0]  load_a;
  logic            start;
  logic            add_en;
  logic            busy;
  logic            done;
  logic            out_valid;
  logic [N-1:0]    out_lane_valid;
  logic [N*W-1:0]  out_data;

  modport master (
    output load_en, load_row, load_r, load_a, start, add_en,
    input  busy, done, out_valid, out_lane_valid, out_data
  );

  modport slave (
    input  load_en, load_row, load_r, load_a, start, add_en,
    output busy, done, out_valid, out_lane_valid, out_data
  );
endinterface

// File: rtl/skew_dispatcher.sv
// Buffers N x N matrices R and A, then streams R (or R+A) column-skewed over N lanes.
// Define ACC_SAT_EN to make the add mode saturate as unsigned instead of wrapping.
module skew_dispatcher #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int CW = $clog2(2*N)
) (
  input logic              clk,
  input logic              rst,
  skew_dispatcher_if.slave bus
);
  localparam int            RW        = $clog2(N);
  localparam logic [CW-1:0] DONE_STEP = CW'(2*N-1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  step_q, step_d;
  logic           mode_q, mode_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   lane_valid_q, lane_valid_d;
  logic [N*W-1:0] data_q, data_d;
  logic [N-1:0]   skew_valid;
  logic [N*W-1:0] skew_data;

  logic [W-1:0] r_q [N][N];
  logic [W-1:0] a_q [N][N];

  function automatic logic [W-1:0] elem(input logic [W-1:0] r, input logic [W-1:0] a,
                                        input logic add);
`ifdef ACC_SAT_EN
    logic [W:0] sum;
    sum = {1'b0, r} + {1'b0, a};
    if (!add) return r;
    return sum[W] ? '1 : sum[W-1:0];
`else
    if (!add) return r;
    return r + a;
`endif
  endfunction

  // NOTE: the matrices carry a reset so a stream without reload after reset is all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_q[i][j] <= '0;
          a_q[i][j] <= '0;
        end
      end
    end else if (bus.load_en && state_q == IDLE) begin
      // Rows beyond N-1 never match, so out-of-range indices are dropped.
      for (int i = 0; i < N; i++) begin
        if (bus.load_row == RW'(i)) begin
          for (int j = 0; j < N; j++) begin
            r_q[i][j] <= bus.load_r[j*W +: W];
            a_q[i][j] <= bus.load_a[j*W +: W];
          end
        end
      end
    end
  end

  // Lane j at step t carries row t-j, i.e. the row i with i + j == t.
  always_comb begin
    skew_valid = '0;
    skew_data  = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (int'(step_q) == i + j) begin
          skew_valid[j]        = 1'b1;
          skew_data[j*W +: W]  = elem(r_q[i][j], a_q[i][j], mode_q);
        end
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    mode_d       = mode_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    valid_d      = 1'b0;
    lane_valid_d = '0;
    data_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          step_d  = '0;
          mode_d  = bus.add_en;
        end
      end
      STREAM: begin
        busy_d = 1'b1;
        if (step_q == DONE_STEP) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          valid_d      = 1'b1;
          lane_valid_d = skew_valid;
          data_d       = skew_data;
          step_d       = step_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      step_q       <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      lane_valid_q <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      lane_valid_q <= lane_valid_d;
      data_q       <= data_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.out_valid      = valid_q;
  assign bus.out_lane_valid = lane_valid_q;
  assign bus.out_data       = data_q;
endmodule

// File: tb/tb_skew_dispatcher.sv
// Self-checking bench for skew_dispatcher: N=4/W=32 instance against a matrix model,
// plus an N=2/W=8 instance for the parameter sweep.
module tb_skew_dispatcher;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  skew_dispatcher_if #(.N(N), .W(W)) bus4 ();
  skew_dispatcher_if #(.N(2), .W(8)) bus2 ();

  skew_dispatcher #(.N(N), .W(W)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  skew_dispatcher #(.N(2), .W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] rm [N][N];
  logic [W-1:0] am [N][N];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_elem(input logic [W-1:0] r, input logic [W-1:0] a,
                                              input bit mode);
    logic [63:0] s;
    if (!mode) return r;
    s = 64'(r) + 64'(a);
`ifdef ACC_SAT_EN
    if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return s[W-1:0];
  endfunction

  // Output step t: lane j shows element (t-j, j) when that row exists.
  function automatic void model_step(input int t, input bit mode,
                                     output logic [N-1:0] lv, output logic [N*W-1:0] d);
    lv = '0;
    d  = '0;
    for (int j = 0; j < N; j++) begin
      int i = t - j;
      if (i >= 0 && i < N) begin
        lv[j]        = 1'b1;
        d[j*W +: W]  = model_elem(rm[i][j], am[i][j], mode);
      end
    end
  endfunction

  task automatic load4(input int row, input logic [N*W-1:0] r, input logic [N*W-1:0] a);
    bus4.load_en  = 1'b1;
    bus4.load_row = 2'(row);
    bus4.load_r   = r;
    bus4.load_a   = a;
    tick();
    bus4.load_en  = 1'b0;
    for (int j = 0; j < N; j++) begin
      rm[row][j] = r[j*W +: W];
      am[row][j] = a[j*W +: W];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rm[i][j] = '0;
        am[i][j] = '0;
      end
  endtask

  task automatic run_stream(input bit mode, input bit poke_start, input bit poke_load,
                            input int co_row, input string tag);
    logic [N-1:0]   elv;
    logic [N*W-1:0] ed;
    logic [N*W-1:0] nr, na;
    bus4.add_en = mode;
    bus4.start  = 1'b1;
    if (co_row >= 0) begin
      nr = {$urandom, $urandom, $urandom, $urandom};
      na = {$urandom, $urandom, $urandom, $urandom};
      bus4.load_en  = 1'b1;
      bus4.load_row = 2'(co_row);
      bus4.load_r   = nr;
      bus4.load_a   = na;
      for (int j = 0; j < N; j++) begin
        rm[co_row][j] = nr[j*W +: W];
        am[co_row][j] = na[j*W +: W];
      end
    end
    tick();
    bus4.start   = 1'b0;
    bus4.load_en = 1'b0;
    bus4.add_en  = ~mode;
    check($sformatf("%s/busy_at_start", tag), bus4.busy, 0);
    for (int t = 0; t < 2*N-1; t++) begin
      if (poke_start && t == 1) bus4.start = 1'b1;
      if (poke_load && t == 2) begin
        bus4.load_en  = 1'b1;
        bus4.load_row = '0;
        bus4.load_r   = {N{32'h5555_5555}};
        bus4.load_a   = {N{32'h5555_5555}};
      end
      tick();
      bus4.start   = 1'b0;
      bus4.load_en = 1'b0;
      model_step(t, mode, elv, ed);
      check($sformatf("%s/valid t%0d", tag, t), bus4.out_valid, 1);
      check($sformatf("%s/lane_valid t%0d", tag, t), bus4.out_lane_valid, elv);
      check($sformatf("%s/data t%0d", tag, t), bus4.out_data, ed);
      check($sformatf("%s/busy t%0d", tag, t), bus4.busy, 1);
      check($sformatf("%s/done t%0d", tag, t), bus4.done, 0);
    end
    tick();
    check($sformatf("%s/done_pulse", tag), bus4.done, 1);
    check($sformatf("%s/done_valid", tag), bus4.out_valid, 0);
    check($sformatf("%s/done_lane_valid", tag), bus4.out_lane_valid, 0);
    check($sformatf("%s/done_data", tag), bus4.out_data, 0);
    check($sformatf("%s/done_busy", tag), bus4.busy, 1);
    if (poke_start) bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    check($sformatf("%s/idle_busy", tag), bus4.busy, 0);
    check($sformatf("%s/idle_done", tag), bus4.done, 0);
    tick();
    check($sformatf("%s/idle_valid", tag), bus4.out_valid, 0);
    check($sformatf("%s/idle_busy2", tag), bus4.busy, 0);
  endtask

  initial begin
    logic [N*W-1:0] r_row, a_row;
    bus4.load_en = 0; bus4.load_row = '0; bus4.load_r = '0; bus4.load_a = '0;
    bus4.start = 0; bus4.add_en = 0;
    bus2.load_en = 0; bus2.load_row = '0; bus2.load_r = '0; bus2.load_a = '0;
    bus2.start = 0; bus2.add_en = 0;
    clear_model();

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset/busy", bus4.busy, 0);
    check("reset/done", bus4.done, 0);
    check("reset/valid", bus4.out_valid, 0);
    check("reset/lane_valid", bus4.out_lane_valid, 0);
    check("reset/data", bus4.out_data, 0);
    check("reset/n2_busy", bus2.busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // N=2, W=8 sweep: R = {{1,2},{3,4}}
    bus2.load_en = 1; bus2.load_row = 1'b0; bus2.load_r = {8'd2, 8'd1};
    tick();
    bus2.load_row = 1'b1; bus2.load_r = {8'd4, 8'd3};
    tick();
    bus2.load_en = 0; bus2.start = 1;
    tick();
    bus2.start = 0;
    tick();
    check("n2/t0 lane_valid", bus2.out_lane_valid, 2'b01);
    check("n2/t0 data", bus2.out_data, 16'h0001);
    tick();
    check("n2/t1 lane_valid", bus2.out_lane_valid, 2'b11);
    check("n2/t1 data", bus2.out_data, 16'h0203);
    tick();
    check("n2/t2 lane_valid", bus2.out_lane_valid, 2'b10);
    check("n2/t2 data", bus2.out_data, 16'h0400);
    check("n2/t2 valid", bus2.out_valid, 1);
    tick();
    check("n2/done", bus2.done, 1);
    check("n2/done_valid", bus2.out_valid, 0);
    tick();
    check("n2/idle_busy", bus2.busy, 0);

    // Pass mode skew with R[i][j] = 4i+j, A = 0; second start during STREAM is ignored
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) r_row[j*W +: W] = W'(4*i + j);
      load4(i, r_row, '0);
    end
    run_stream(1'b0, 1'b1, 1'b0, -1, "pass");

    // Add mode with A = 0x100; load attempted mid-stream must be dropped
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) r_row[j*W +: W] = W'(4*i + j);
      load4(i, r_row, {N{32'h0000_0100}});
    end
    run_stream(1'b1, 1'b0, 1'b1, -1, "add");
    run_stream(1'b0, 1'b0, 1'b0, -1, "after_blocked_load");

    // Wrap / saturate on element (0,0)
    r_row = {32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF};
    a_row = {32'h100, 32'h100, 32'h100, 32'd2};
    load4(0, r_row, a_row);
    run_stream(1'b1, 1'b0, 1'b0, -1, "wrap");

    // Load coinciding with start, then random matrices in both modes
    run_stream(1'b1, 1'b0, 1'b0, 2, "co_load");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++)
        load4(i, {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom});
      run_stream(1'($urandom_range(0, 1)), 1'b0, 1'b0, -1, $sformatf("rand%0d", k));
    end

    // Reset during step 2: outputs clear asynchronously and no done follows
    bus4.add_en = 1'b1;
    bus4.start  = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    tick();
    check("midrst/valid_before", bus4.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst/valid", bus4.out_valid, 0);
    check("midrst/busy", bus4.busy, 0);
    check("midrst/lane_valid", bus4.out_lane_valid, 0);
    check("midrst/data", bus4.out_data, 0);
    check("midrst/done", bus4.done, 0);
    tick();
    rst = 1'b0;
    clear_model();
    for (int c = 0; c < 2*N+1; c++) begin
      tick();
      check($sformatf("midrst/no_done c%0d", c), bus4.done, 0);
      check($sformatf("midrst/no_valid c%0d", c), bus4.out_valid, 0);
    end
    run_stream(1'b1, 1'b0, 1'b0, -1, "cleared");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/skew_dispatcher.md
Name: skew_dispatcher

Overview:
- Parametrised successor to the fixed 4x4 dispatcher: buffers an N x N operand matrix R and an accumulator matrix A, then streams R (or R+A) column-skewed over N lanes for a systolic array.
- Owns its own step counter and start/busy/done handshake, instead of taking an external count.
- Sits between the matrix load path and the systolic array's column inputs.

Parameters:
- N, 4, array dimension: lanes, rows and columns; N >= 2.
- W, 32, element width in bits.
- CW, $clog2(2*N), step counter width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- load_en  in  1  write one row of R and A; ignored while busy.
- load_row  in  $clog2(N)  row index for the load.
- load_r  in  N*W  row of R; element j at bits [j*W +: W].
- load_a  in  N*W  row of A; same packing.
- start  in  1  begin streaming; sampled only in IDLE.
- add_en  in  1  mode select, latched at start: 0 = pass R, 1 = R+A.
- busy  out  1  high while streaming or in DONE.
- done  out  1  one-cycle pulse after the last output step.
- out_valid  out  1  output step present.
- out_lane_valid  out  N  per-lane element valid.
- out_data  out  N*W  lane j at bits [j*W +: W].

Behaviour:
- Reset, asynchronous: state=IDLE; step=0; mode=0; busy, done, out_valid, out_lane_valid, out_data = 0; all R and A storage cleared to 0. Reset mid-stream aborts immediately; no done is produced.
- Loads:
  - On an edge with load_en=1 and state=IDLE, R[load_row] <= load_r and A[load_row] <= load_a.
  - If load_en and start coincide in IDLE, the load is written first; the stream uses the new row.
  - An out-of-range load_row, possible only when N is not a power of 2, is ignored.
- State machine IDLE -> STREAM -> DONE -> IDLE:
  - IDLE: start=1 at edge k latches add_en into mode, sets step=0 and moves to STREAM. busy=1 from edge k+1.
  - STREAM: each edge registers output step t=step, then increments step. After step 2N-2 is registered, moves to DONE.
  - DONE: lasts one cycle with done=1, out_valid=0, out_lane_valid=0 and out_data held at 0. The next edge returns to IDLE with busy=0.
  - start is ignored in STREAM and DONE.
- Output step t, for t = 0..2N-2:
  - Lane j selects row i = t-j, column j.
  - If 0 <= i < N: out_lane_valid[j]=1 and the element is R[i][j], or R[i][j]+A[i][j] when mode=1. The add is W-bit and wraps modulo 2^W.
  - Otherwise out_lane_valid[j]=0 and the lane data is 0.
  - out_valid=1 for every step.
- Latency: step 0 appears at the registered outputs after edge k+1. Exactly 2N-1 consecutive out_valid cycles follow. done is high in the cycle after edge k+2N.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro ACC_SAT_EN.
- When defined: the add mode saturates as unsigned; a sum >= 2^W outputs all-ones (W bits).
- When undefined: the add wraps modulo 2^W.
- Pass mode is identical either way.

Test Plan:
- Skew, pass mode, N=4, W=32: load R[i][j]=4i+j with A=0, add_en=0, pulse start. Expected:
  - Step 0: lane0=0, lane_valid=0001.
  - Step 3: lanes 12, 9, 6, 3, lane_valid=1111.
  - Step 6: lane3=15, lane_valid=1000.
  - 7 out_valid cycles, then a 1-cycle done, then busy=0.
- Add mode: R as above, A[i][j]=0x100, add_en=1. Step 3 lanes = 0x10C, 0x109, 0x106, 0x103.
- Wrap/saturate: R[0][0]=0xFFFFFFFF, A[0][0]=2, add_en=1. Step 0 lane0 = 0x00000001 without ACC_SAT_EN, 0xFFFFFFFF with it.
- Handshake guards:
  - start pulsed again during STREAM: ignored, still exactly 7 output steps.
  - load_en during STREAM with load_row=0, load_r=all 0x55: R unchanged; the next stream step 0 lane0 is still 0.
- Reset mid-stream: assert rst during step 2. Outputs go to 0 asynchronously with no done. After release, a stream without reload outputs all-zero data on valid lanes (storage cleared).
- Parameter sweep, N=2, W=8: R={{1,2},{3,4}}. Expect 3 steps: (1,-) valid 01; (3,2) valid 11; (-,4) valid 10.
